encoder8to3_seq: RTL and testbench

//  Registered 8-to-3 priority encoder with request capture and valid/ready output;
//  the inverse of the 3-to-8 decoder. Request lines D are latched into a sticky pending

---
 rtl/encoder8to3_seq_pkg.sv | 13 +
 rtl/encoder8to3_seq_prio_enc8.sv | 26 ++
 rtl/encoder8to3_seq.sv | 97 +++++++++
 tb/tb_encoder8to3_seq.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/encoder8to3_seq_pkg.sv
// Shared definitions for the sequential 8-to-3 priority encoder:
// FSM state encoding and default widths.
package encoder8to3_seq_pkg;

  localparam int N_IN_DEF  = 8;
  localparam int W_OUT_DEF = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/encoder8to3_seq_prio_enc8.sv
// Combinational priority encoder: returns the highest set index of vec,
// plus a flag telling whether any bit is set at all.
module prio_enc8
  import encoder8to3_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic [N_IN-1:0]  vec,
  output logic [W_OUT-1:0] idx,
  output logic             any
);

  // Ascending scan; later (higher) hits overwrite earlier ones.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (vec[i]) begin
        idx = W_OUT'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder8to3_seq.sv
// Registered priority encoder: sticky request capture, highest-index-first
// grant on A, held under a valid/ready handshake until accepted.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ST_IDLE | no grant outstanding; loads prio(pending) when anything pends
//   ST_HOLD | A/out_valid presented, held until out_ready; no preemption
module encoder8to3_seq
  import encoder8to3_seq_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int W_OUT = W_OUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  D,
  input  logic             out_ready,
  output logic [W_OUT-1:0] A,
  output logic             out_valid,
  output logic [N_IN-1:0]  pending,
  output logic             multi
);

  state_t            state_q, state_nx;
  logic [W_OUT-1:0]  a_nx;
  logic              valid_nx;
  logic [N_IN-1:0]   onehot_a, clr_mask, pend_nx, rem;
  logic [W_OUT-1:0]  pend_idx, rem_idx;
  logic              pend_any, rem_any;
  logic              hs;

  assign hs       = out_valid & out_ready;
  assign onehot_a = N_IN'(1) << A;
  assign clr_mask = hs ? onehot_a : '0;
  // Set wins over clear: a fresh request on the accepted bit stays pending.
  assign pend_nx  = (pending & ~clr_mask) | D;
  // rem excludes same-cycle D so new arrivals are granted from IDLE.
  assign rem      = pending & ~onehot_a;
  assign multi    = |(pending & (pending - N_IN'(1)));

  prio_enc8 #(.N_IN(N_IN), .W_OUT(W_OUT)) u_prio_pend (
    .vec (pending),
    .idx (pend_idx),
    .any (pend_any)
  );

  prio_enc8 #(.N_IN(N_IN), .W_OUT(W_OUT)) u_prio_rem (
    .vec (rem),
    .idx (rem_idx),
    .any (rem_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending   <= '0;
      A         <= '0;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_nx;
      pending   <= pend_nx;
      A         <= a_nx;
      out_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (pend_any)        state_nx = ST_HOLD;
      ST_HOLD: if (hs && !rem_any)  state_nx = ST_IDLE;
      default:                      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    a_nx     = A;
    valid_nx = out_valid;
    case (state_q)
      ST_IDLE: begin
        valid_nx = 1'b0;
        if (pend_any) begin
          a_nx     = pend_idx;
          valid_nx = 1'b1;
        end
      end
      ST_HOLD: begin
        if (hs) begin
          if (rem_any) a_nx     = rem_idx;
          else         valid_nx = 1'b0;
        end
      end
      default: valid_nx = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_encoder8to3_seq.sv
// Bench for encoder8to3_seq: directed scenarios plus random traffic, all
// compared against a set-based reference model of the grant behaviour.
module tb_encoder8to3_seq;

  logic       clk;
  logic       rst;
  logic [7:0] D;
  logic       out_ready;
  logic [2:0] A;
  logic       out_valid;
  logic [7:0] pending;
  logic       multi;

  int n_chk  = 0;
  int n_fail = 0;

  int m_pend  = 0;
  int m_a     = 0;
  bit m_valid = 1'b0;

  encoder8to3_seq dut (
    .clk       (clk),
    .rst       (rst),
    .D         (D),
    .out_ready (out_ready),
    .A         (A),
    .out_valid (out_valid),
    .pending   (pending),
    .multi     (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Highest set bit index, from floor(log2(v)).
  function automatic int top_idx(input int v);
    return $clog2(v + 1) - 1;
  endfunction

  task automatic model_update(input bit r, input int d, input bit rdy);
    int old_pend, rem;
    bit accept;
    if (r) begin
      m_pend  = 0;
      m_a     = 0;
      m_valid = 1'b0;
      return;
    end
    old_pend = m_pend;
    accept   = m_valid && rdy;
    if (accept) m_pend = m_pend & ~(1 << m_a);
    m_pend = m_pend | d;
    if (!m_valid) begin
      if (old_pend != 0) begin
        m_a     = top_idx(old_pend);
        m_valid = 1'b1;
      end
    end else if (accept) begin
      rem = old_pend & ~(1 << m_a);
      if (rem != 0) m_a = top_idx(rem);
      else          m_valid = 1'b0;
    end
  endtask

  task automatic step(input bit r, input logic [7:0] d, input bit rdy);
    rst       = r;
    D         = d;
    out_ready = rdy;
    @(posedge clk);
    model_update(r, int'(d), rdy);
    @(negedge clk);
    chk_eq("pending", int'(pending), m_pend);
    chk_eq("out_valid", int'(out_valid), int'(m_valid));
    chk_eq("multi", int'(multi), int'($countones(m_pend) > 1));
    if (m_valid) chk_eq("A", int'(A), m_a);
  endtask

  initial begin
    rst       = 1'b1;
    D         = 8'h00;
    out_ready = 1'b0;

    // Reset with all requests high
    step(1, 8'hFF, 0);
    step(1, 8'hFF, 0);
    chk_eq("rst_pending", int'(pending), 0);
    chk_eq("rst_valid", int'(out_valid), 0);
    chk_eq("rst_A", int'(A), 0);

    // Single request, consumer always ready
    step(0, 8'h04, 1);
    chk_eq("t2_valid_lat1", int'(out_valid), 0);
    step(0, 8'h00, 1);
    chk_eq("t2_valid", int'(out_valid), 1);
    chk_eq("t2_A", int'(A), 2);
    step(0, 8'h00, 1);
    chk_eq("t2_valid_drop", int'(out_valid), 0);
    chk_eq("t2_pending", int'(pending), 0);

    // Two requests, long stall then accept both back-to-back
    step(0, 8'h81, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 0);
    chk_eq("t3_A_held", int'(A), 7);
    chk_eq("t3_multi", int'(multi), 1);
    step(0, 8'h00, 1);
    chk_eq("t3_A_next", int'(A), 0);
    chk_eq("t3_valid_next", int'(out_valid), 1);
    step(0, 8'h00, 1);
    chk_eq("t3_valid_end", int'(out_valid), 0);

    // No preemption by higher-priority arrival
    step(0, 8'h08, 0);
    step(0, 8'h00, 0);
    chk_eq("t4_A3", int'(A), 3);
    step(0, 8'h80, 0);
    step(0, 8'h00, 0);
    chk_eq("t4_A3_kept", int'(A), 3);
    step(0, 8'h00, 1);
    chk_eq("t4_A7", int'(A), 7);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Re-request on the accepted bit in the handshake cycle
    step(0, 8'h20, 0);
    step(0, 8'h00, 0);
    chk_eq("t5_A5", int'(A), 5);
    step(0, 8'h20, 1);
    chk_eq("t5_pend5", int'(pending[5]), 1);
    chk_eq("t5_valid_idle", int'(out_valid), 0);
    step(0, 8'h00, 0);
    chk_eq("t5_regrant", int'(A), 5);
    chk_eq("t5_regrant_v", int'(out_valid), 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);

    // Reset while holding a grant
    step(0, 8'h43, 0);
    step(0, 8'h00, 0);
    chk_eq("t6_A6", int'(A), 6);
    step(1, 8'h00, 0);
    chk_eq("t6_valid", int'(out_valid), 0);
    chk_eq("t6_pending", int'(pending), 0);
    step(0, 8'h02, 1);
    step(0, 8'h00, 1);
    chk_eq("t6_A1", int'(A), 1);
    step(0, 8'h00, 1);

    // Random traffic: sparse requests, bursty ready, rare reset
    for (int i = 0; i < 1500; i++) begin
      bit         r;
      logic [7:0] d;
      bit         rdy;
      r   = ($urandom_range(0, 63) == 0);
      d   = 8'($urandom & $urandom & $urandom);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, d, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
